// File: rtl/param_pipe_core_if.sv
// Instruction offer port for param_pipe_core: valid/ready handshake carrying
// one encoded instruction {op[2:0], rs1, rs2, rd} (SET: {op, imm, rd}).
interface param_pipe_core_if #(
   parameter int unsigned NREG = 4
);
   localparam int unsigned RW = $clog2(NREG);
   localparam int unsigned IW = 3 + 3 * RW;

   logic [IW-1:0] inst;
   logic          inst_valid;
   logic          inst_ready;

   modport master (output inst, output inst_valid, input inst_ready);
   modport slave  (input inst, input inst_valid, output inst_ready);
endinterface

// File: rtl/param_pipe_core.sv
// Parametrised 3-stage (ID|EX|WB) pipeline with scoreboard-driven operand
// forwarding, 8-op ALU, synchronous flush and a retire counter.
// Operands are resolved in ID and carried as values, so RAW hazards never
// stall: the newest in-flight writer (EX, then WB) wins over the RF.
module param_pipe_core #(
   parameter int unsigned DW   = 8,
   parameter int unsigned NREG = 4,
   parameter int unsigned CNTW = 16,
   localparam int unsigned RW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   param_pipe_core_if.slave in_if,
   input  logic            stallex,
   input  logic            stallwb,
   input  logic            flush,
   input  logic [RW-1:0]   rf_rd_addr,
   output logic [DW-1:0]   rf_rd_data,
   output logic [CNTW-1:0] retire_cnt
);
   localparam int unsigned IW = 3 + 3 * RW;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_ADD  = 3'd1,
      OP_SET  = 3'd2,
      OP_NAND = 3'd3,
      OP_SUB  = 3'd4,
      OP_AND  = 3'd5,
      OP_OR   = 3'd6,
      OP_XOR  = 3'd7
   } op_e;

   // architectural and pipeline state
   logic [DW-1:0]        rf_q [NREG];
   logic [DW-1:0]        rf_d [NREG];
   logic [NREG-1:0][1:0] sb_q, sb_d;
   logic                 id_ex_valid_q, id_ex_valid_d;
   logic                 id_ex_wen_q, id_ex_wen_d;
   op_e                  id_ex_op_q, id_ex_op_d;
   logic [RW-1:0]        id_ex_rd_q, id_ex_rd_d;
   logic [DW-1:0]        id_ex_a_q, id_ex_a_d;
   logic [DW-1:0]        id_ex_b_q, id_ex_b_d;
   logic                 ex_wb_valid_q, ex_wb_valid_d;
   logic                 ex_wb_wen_q, ex_wb_wen_d;
   logic [RW-1:0]        ex_wb_rd_q, ex_wb_rd_d;
   logic [DW-1:0]        ex_wb_val_q, ex_wb_val_d;
   logic [CNTW-1:0]      retire_cnt_q, retire_cnt_d;

   // decode / handshake / datapath nets
   op_e                  dec_op;
   logic [RW-1:0]        dec_rs1, dec_rs2, dec_rd;
   logic [2*RW-1:0]      dec_imm;
   logic [DW-1:0]        opnd_a, opnd_b, ex_res;
   logic                 wb_ready, ex_ready, inst_ready;
   logic                 id_go, ex_go, wb_go;

   // field extraction from the offered instruction
   always_comb begin
      dec_op  = op_e'(in_if.inst[IW-1 -: 3]);
      dec_rs1 = in_if.inst[3*RW-1 -: RW];
      dec_rs2 = in_if.inst[2*RW-1 -: RW];
      dec_rd  = in_if.inst[RW-1:0];
      dec_imm = in_if.inst[3*RW-1:RW];
   end

   // per-stage handshake and go strobes; flush blocks every go
   always_comb begin
      wb_ready         = !stallwb;
      ex_ready         = !stallex && (wb_ready || !ex_wb_valid_q);
      inst_ready       = !flush && (ex_ready || !id_ex_valid_q);
      id_go            = in_if.inst_valid && inst_ready;
      ex_go            = id_ex_valid_q && ex_ready && !flush;
      wb_go            = ex_wb_valid_q && wb_ready && !flush;
      in_if.inst_ready = inst_ready;
   end

   // EX ALU; also the youngest forwarding source
   always_comb begin
      ex_res = '0;
      case (id_ex_op_q)
         OP_ADD:  ex_res = id_ex_a_q + id_ex_b_q;
         OP_SET:  ex_res = id_ex_a_q;
         OP_NAND: ex_res = ~(id_ex_a_q & id_ex_b_q);
         OP_SUB:  ex_res = id_ex_a_q - id_ex_b_q;
         OP_AND:  ex_res = id_ex_a_q & id_ex_b_q;
         OP_OR:   ex_res = id_ex_a_q | id_ex_b_q;
         OP_XOR:  ex_res = id_ex_a_q ^ id_ex_b_q;
         default: ex_res = '0;
      endcase
   end

   // operand select: EX writer, else WB writer, else RF; SET uses the immediate
   always_comb begin
      opnd_a = rf_q[dec_rs1];
      if (sb_q[dec_rs1][1]) begin
         opnd_a = ex_res;
      end else if (sb_q[dec_rs1][0]) begin
         opnd_a = ex_wb_val_q;
      end
      opnd_b = rf_q[dec_rs2];
      if (sb_q[dec_rs2][1]) begin
         opnd_b = ex_res;
      end else if (sb_q[dec_rs2][0]) begin
         opnd_b = ex_wb_val_q;
      end
      if (dec_op == OP_SET) begin
         opnd_a = DW'(dec_imm);
      end
   end

   // next state of stage registers, RF, counter and scoreboard
   always_comb begin
      id_ex_valid_d = id_ex_valid_q;
      id_ex_wen_d   = id_ex_wen_q;
      id_ex_op_d    = id_ex_op_q;
      id_ex_rd_d    = id_ex_rd_q;
      id_ex_a_d     = id_ex_a_q;
      id_ex_b_d     = id_ex_b_q;
      ex_wb_valid_d = ex_wb_valid_q;
      ex_wb_wen_d   = ex_wb_wen_q;
      ex_wb_rd_d    = ex_wb_rd_q;
      ex_wb_val_d   = ex_wb_val_q;
      rf_d          = rf_q;
      retire_cnt_d  = retire_cnt_q + CNTW'(wb_go);
      sb_d          = '0;

      if (flush) begin
         id_ex_valid_d = 1'b0;
      end else if (id_go) begin
         id_ex_valid_d = 1'b1;
         id_ex_wen_d   = (dec_op != OP_NOP);
         id_ex_op_d    = dec_op;
         id_ex_rd_d    = dec_rd;
         id_ex_a_d     = opnd_a;
         id_ex_b_d     = opnd_b;
      end else if (ex_go) begin
         id_ex_valid_d = 1'b0;
      end

      if (flush) begin
         ex_wb_valid_d = 1'b0;
      end else if (ex_go) begin
         ex_wb_valid_d = 1'b1;
         ex_wb_wen_d   = id_ex_wen_q;
         ex_wb_rd_d    = id_ex_rd_q;
         ex_wb_val_d   = ex_res;
      end else if (wb_go) begin
         ex_wb_valid_d = 1'b0;
      end

      if (wb_go && ex_wb_wen_q) begin
         rf_d[ex_wb_rd_q] = ex_wb_val_q;
      end

      // scoreboard tracks the stage contents it will sit beside next cycle
      for (int unsigned r = 0; r < NREG; r++) begin
         sb_d[r][1] = id_ex_valid_d && id_ex_wen_d && (id_ex_rd_d == RW'(r));
         sb_d[r][0] = ex_wb_valid_d && ex_wb_wen_d && (ex_wb_rd_d == RW'(r));
      end
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_valid_q <= 1'b0;
         id_ex_wen_q   <= 1'b0;
         id_ex_op_q    <= OP_NOP;
         id_ex_rd_q    <= '0;
         id_ex_a_q     <= '0;
         id_ex_b_q     <= '0;
         ex_wb_valid_q <= 1'b0;
         ex_wb_wen_q   <= 1'b0;
         ex_wb_rd_q    <= '0;
         ex_wb_val_q   <= '0;
         retire_cnt_q  <= '0;
         sb_q          <= '0;
         for (int unsigned i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         id_ex_valid_q <= id_ex_valid_d;
         id_ex_wen_q   <= id_ex_wen_d;
         id_ex_op_q    <= id_ex_op_d;
         id_ex_rd_q    <= id_ex_rd_d;
         id_ex_a_q     <= id_ex_a_d;
         id_ex_b_q     <= id_ex_b_d;
         ex_wb_valid_q <= ex_wb_valid_d;
         ex_wb_wen_q   <= ex_wb_wen_d;
         ex_wb_rd_q    <= ex_wb_rd_d;
         ex_wb_val_q   <= ex_wb_val_d;
         retire_cnt_q  <= retire_cnt_d;
         sb_q          <= sb_d;
         rf_q          <= rf_d;
      end
   end

   // debug read port and counter output
   always_comb begin
      rf_rd_data = rf_q[rf_rd_addr];
      retire_cnt = retire_cnt_q;
   end
endmodule
